// File: rtl/decode_pkg.sv
// ---------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the fetch->decode instruction queue.
//   fetch_entry_t : one fetched instruction plus its fetch-side exception flags
//   OP_* / FN_*   : primary opcode and SPECIAL funct codes of control transfers
//   is_cti()      : pre-decode of a raw instruction word; 1 for branches/jumps
//                   that own a delay slot
// ---------------------------------------------------------------------------
package decode_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] raw_instr;
      logic        exception_instr;
      logic        i_tlb_refill;
      logic        i_tlb_invalid;
      logic        i_tlb_modified;
   } fetch_entry_t;

   // Primary opcodes (instr[31:26])
   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_REGIMM  = 6'b000001;   // bltz/bgez/bltzal/bgezal
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_BNE     = 6'b000101;
   localparam logic [5:0] OP_BLEZ    = 6'b000110;
   localparam logic [5:0] OP_BGTZ    = 6'b000111;

   // SPECIAL funct codes (instr[5:0])
   localparam logic [5:0] FN_JR      = 6'b001000;
   localparam logic [5:0] FN_JALR    = 6'b001001;

   function automatic logic is_cti(input logic [31:0] instr);
      logic [5:0] op;
      logic [5:0] fn;
      logic       hit;
      op  = instr[31:26];
      fn  = instr[5:0];
      hit = 1'b0;
      case (op)
         OP_REGIMM, OP_J, OP_JAL,
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: hit = 1'b1;
         OP_SPECIAL: hit = (fn == FN_JR) || (fn == FN_JALR);
         default:    hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/decode_queue_select.sv
// ---------------------------------------------------------------------------
// decode_queue_select
// Combinational issue-group former. Looks at the entries sitting at the queue
// head and decides which lanes may issue this cycle so that a branch/jump
// never leaves without its delay slot.
//   cand_entry        : entries head+0 .. head+ISSUE_WIDTH-1 (may be stale)
//   count             : queue occupancy; lane i is a candidate when i < count
//   ds_pending        : last dequeued instruction was a CTI
//   out_valid         : contiguous per-lane issue valid
//   out_in_delay_slot : per-lane "this is a delay-slot instruction" flag
// ---------------------------------------------------------------------------
module decode_queue_select
   import decode_pkg::*;
#(
   parameter int ISSUE_WIDTH = 2,
   parameter int DEPTH       = 8
) (
   input  fetch_entry_t                 cand_entry [ISSUE_WIDTH],
   input  logic [$clog2(DEPTH):0]       count,
   input  logic                         ds_pending,
   output logic [ISSUE_WIDTH-1:0]       out_valid,
   output logic [ISSUE_WIDTH-1:0]       out_in_delay_slot
);

   localparam int CW = $clog2(DEPTH) + 1;

   // One spare bit above the last lane so "is lane i+1 a candidate" can be
   // asked of every lane; the spare is always 0.
   logic [ISSUE_WIDTH:0]   cand;
   logic [ISSUE_WIDTH-1:0] cti;
   logic                   hold;

   // NOTE: every variable written in an always_comb gets a default at the top
   // of the block, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      cand = '0;
      cti  = '0;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         cand[i] = (CW'(i) < count);
         cti[i]  = is_cti(cand_entry[i].raw_instr);
      end
   end

   // The first candidate CTI whose delay slot is not in this group (either the
   // slot has not arrived yet or the CTI sits in the last lane) stops the group
   // there; it issues later together with its slot. A single-lane decoder
   // cannot pair anything, so it never holds.
   always_comb begin
      out_valid = '0;
      hold      = 1'b0;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         if (ISSUE_WIDTH == 1) begin
            out_valid[i] = cand[i];
         end else if (cand[i] && !hold) begin
            if (cti[i] && ((i == ISSUE_WIDTH - 1) || !cand[i+1]))
               hold = 1'b1;
            else
               out_valid[i] = 1'b1;
         end
      end
   end

   // Lane 0 inherits the slot state from the previous group; every other lane
   // is a delay slot exactly when the lane below it holds a CTI.
   always_comb begin
      out_in_delay_slot    = '0;
      out_in_delay_slot[0] = ds_pending;
      for (int i = 1; i < ISSUE_WIDTH; i++)
         out_in_delay_slot[i] = cti[i-1];
   end

   // Only raw_instr matters for grouping; the remaining fields pass through
   // the top module untouched.
   logic [ISSUE_WIDTH-1:0] unused_fields;
   for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_unused
      assign unused_fields[g] = ^{cand_entry[g].pc, cand_entry[g].raw_instr,
                                  cand_entry[g].exception_instr,
                                  cand_entry[g].i_tlb_refill,
                                  cand_entry[g].i_tlb_invalid,
                                  cand_entry[g].i_tlb_modified};
   end

endmodule

// File: rtl/decode_queue.sv
// ---------------------------------------------------------------------------
// decode_queue
// Instruction buffer between fetch and decode. Takes up to FETCH_WIDTH
// instructions per cycle, presents up to ISSUE_WIDTH head-ordered instructions
// per cycle, keeps every CTI in the same issue group as its delay slot and
// flags delay-slot lanes for the decoder.
//   clk, reset          : clock, asynchronous active-high reset
//   flush               : drop all contents (exception, eret, mispredict)
//   in_valid/in_entry   : fetch lanes, valid contiguous from lane 0
//   in_ready            : at least FETCH_WIDTH entries free
//   out_valid/out_entry : decode lanes, valid contiguous from lane 0
//   out_in_delay_slot   : lane holds a delay-slot instruction
//   out_ready           : decode takes every valid lane this cycle
//   count               : current occupancy
// ---------------------------------------------------------------------------
module decode_queue
   import decode_pkg::*;
#(
   parameter int FETCH_WIDTH = 2,
   parameter int ISSUE_WIDTH = 2,
   parameter int DEPTH       = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic [FETCH_WIDTH-1:0]   in_valid,
   input  fetch_entry_t             in_entry [FETCH_WIDTH],
   output logic                     in_ready,
   output logic [ISSUE_WIDTH-1:0]   out_valid,
   output fetch_entry_t             out_entry [ISSUE_WIDTH],
   output logic [ISSUE_WIDTH-1:0]   out_in_delay_slot,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  head;
   logic [AW-1:0]  tail;
   logic           ds_pending;

   logic           enq;
   logic           deq;
   logic [CW-1:0]  n_in;
   logic [CW-1:0]  n_out;
   logic           last_cti;

   // Readiness looks at the current occupancy only; a same-cycle dequeue does
   // not make room for this cycle's write.
   assign in_ready = (count <= CW'(DEPTH - FETCH_WIDTH));
   assign enq      = in_ready & (|in_valid);
   assign deq      = out_ready & (|out_valid);
   assign n_in     = CW'($countones(in_valid));
   assign n_out    = CW'($countones(out_valid));

   // Head-relative view; pointers are AW bits wide so the add wraps modulo
   // DEPTH by itself. Empty lanes show whatever the slot holds.
   always_comb begin
      for (int i = 0; i < ISSUE_WIDTH; i++)
         out_entry[i] = mem[head + AW'(i)];
   end

   decode_queue_select #(
      .ISSUE_WIDTH (ISSUE_WIDTH),
      .DEPTH       (DEPTH)
   ) u_select (
      .cand_entry        (out_entry),
      .count             (count),
      .ds_pending        (ds_pending),
      .out_valid         (out_valid),
      .out_in_delay_slot (out_in_delay_slot)
   );

   // Valid lanes are contiguous, so the highest valid lane is the last one
   // leaving the queue; its CTI status becomes the next group's lane-0 slot flag.
   always_comb begin
      last_cti = 1'b0;
      for (int i = 0; i < ISSUE_WIDTH; i++)
         if (out_valid[i])
            last_cti = is_cti(out_entry[i].raw_instr);
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         ds_pending <= 1'b0;
      end else if (flush) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         ds_pending <= 1'b0;
      end else begin
         if (enq)
            tail <= tail + n_in[AW-1:0];
         if (deq) begin
            head       <= head + n_out[AW-1:0];
            ds_pending <= last_cti;
         end
         count <= count + (enq ? n_in : '0) - (deq ? n_out : '0);
      end
   end

   // NOTE: the storage array is deliberately not reset; occupancy and pointers
   // decide what is valid, and a reset-free array maps onto plain RAM/flops.
   always_ff @(posedge clk) begin
      if (enq && !flush) begin
         for (int i = 0; i < FETCH_WIDTH; i++)
            if (in_valid[i])
               mem[tail + AW'(i)] <= in_entry[i];
      end
   end

   // A lane-n valid without lanes 0..n-1 would make the popcount-based tail
   // advance write to the wrong slots.
   contiguous_in_valid : assert property (@(posedge clk) disable iff (reset)
      ((in_valid & (in_valid + FETCH_WIDTH'(1))) == '0));

endmodule

// File: tb/tb_decode_queue.sv
// ---------------------------------------------------------------------------
// tb_decode_queue
// Table-driven bench for decode_queue (2-in/2-out, depth 8) with a pc
// scoreboard, plus a single-issue instance for the delay-slot register path
// and an asynchronous reset applied mid-stream.
// ---------------------------------------------------------------------------
module tb_decode_queue;
   import decode_pkg::*;

   localparam int FW    = 2;
   localparam int IW    = 2;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   localparam logic [31:0] I_ADDU = 32'h0085_1021;
   localparam logic [31:0] I_LW   = 32'h8C82_0000;
   localparam logic [31:0] I_BEQ  = 32'h1085_0003;
   localparam logic [31:0] I_NOP  = 32'h0000_0000;
   localparam logic [31:0] I_JR   = 32'h03E0_0008;
   localparam logic [31:0] I_J    = 32'h0800_0100;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // dual-issue instance
   logic             flush;
   logic [FW-1:0]    in_valid;
   fetch_entry_t     in_entry [FW];
   logic             in_ready;
   logic [IW-1:0]    out_valid;
   fetch_entry_t     out_entry [IW];
   logic [IW-1:0]    out_ds;
   logic             out_ready;
   logic [CW-1:0]    count;

   // single-issue instance
   logic             flush_s;
   logic [FW-1:0]    in_valid_s;
   fetch_entry_t     in_entry_s [FW];
   logic             in_ready_s;
   logic [0:0]       out_valid_s;
   fetch_entry_t     out_entry_s [1];
   logic [0:0]       out_ds_s;
   logic             out_ready_s;
   logic [CW-1:0]    count_s;

   decode_queue #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_entry(in_entry), .in_ready(in_ready),
      .out_valid(out_valid), .out_entry(out_entry), .out_in_delay_slot(out_ds),
      .out_ready(out_ready), .count(count)
   );

   decode_queue #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(1), .DEPTH(DEPTH)) dut_s (
      .clk(clk), .reset(reset), .flush(flush_s),
      .in_valid(in_valid_s), .in_entry(in_entry_s), .in_ready(in_ready_s),
      .out_valid(out_valid_s), .out_entry(out_entry_s), .out_in_delay_slot(out_ds_s),
      .out_ready(out_ready_s), .count(count_s)
   );

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] sb [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic sb_pop(input string name, input logic [31:0] act);
      if (sb.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: got pc %0h, expected nothing (scoreboard empty)", name, act);
      end else begin
         check(name, 64'(act), 64'(sb.pop_front()));
      end
   endtask

   function automatic fetch_entry_t fe(input logic [31:0] pc, input logic [31:0] instr);
      fetch_entry_t e;
      e = '0;
      e.pc        = pc;
      e.raw_instr = instr;
      return e;
   endfunction

   // One row = inputs driven this cycle + outputs expected while they are held.
   typedef struct {
      logic [1:0]  iv;
      logic [31:0] pc0;
      logic [31:0] ins0;
      logic [31:0] pc1;
      logic [31:0] ins1;
      logic        ordy;
      logic        fl;
      int          cnt;
      logic        ir;
      logic [1:0]  ov;
      logic [1:0]  ds;
      logic [1:0]  dsm;   // which out_in_delay_slot bits are defined this row
   } vec_t;

   vec_t tbl [$];
   vec_t v;

   function automatic vec_t mk(logic [1:0] iv, logic [31:0] pc0, logic [31:0] ins0,
                               logic [31:0] pc1, logic [31:0] ins1, logic ordy, logic fl,
                               int cnt, logic ir, logic [1:0] ov, logic [1:0] ds,
                               logic [1:0] dsm);
      vec_t r;
      r.iv = iv; r.pc0 = pc0; r.ins0 = ins0; r.pc1 = pc1; r.ins1 = ins1;
      r.ordy = ordy; r.fl = fl; r.cnt = cnt; r.ir = ir; r.ov = ov; r.ds = ds; r.dsm = dsm;
      return r;
   endfunction

   initial begin
      reset = 1'b1;
      flush = 1'b0;  in_valid = '0;  out_ready = 1'b0;
      flush_s = 1'b0; in_valid_s = '0; out_ready_s = 1'b0;
      for (int i = 0; i < FW; i++) begin
         in_entry[i]   = '0;
         in_entry_s[i] = '0;
      end

      //                 iv     pc0        ins0    pc1        ins1    ordy  fl  cnt ir  ov     ds     dsm
      tbl.push_back(mk(2'b00, 32'h0,     I_NOP,  32'h0,     I_NOP,  1'b0, 1'b0, 0, 1'b1, 2'b00, 2'b00, 2'b01)); // reset state
      // plain pair
      tbl.push_back(mk(2'b11, 32'h100,   I_ADDU, 32'h104,   I_LW,   1'b0, 1'b0, 0, 1'b1, 2'b00, 2'b00, 2'b01));
      tbl.push_back(mk(2'b00, 32'h0,     I_NOP,  32'h0,     I_NOP,  1'b1, 1'b0, 2, 1'b1, 2'b11, 2'b00, 2'b11));
      // lone branch waits for its slot
      tbl.push_back(mk(2'b01, 32'h200,   I_BEQ,  32'h0,     I_NOP,  1'b0, 1'b0, 0, 1'b1, 2'b00, 2'b00, 2'b01));
      tbl.push_back(mk(2'b00, 32'h0,     I_NOP,  32'h0,     I_NOP,  1'b1, 1'b0, 1, 1'b1, 2'b00, 2'b10, 2'b11));
      tbl.push_back(mk(2'b00, 32'h0,     I_NOP,  32'h0,     I_NOP,  1'b1, 1'b0, 1, 1'b1, 2'b00, 2'b10, 2'b11));
      tbl.push_back(mk(2'b00, 32'h0,     I_NOP,  32'h0,     I_NOP,  1'b1, 1'b0, 1, 1'b1, 2'b00, 2'b10, 2'b11));
      tbl.push_back(mk(2'b01, 32'h204,   I_NOP,  32'h0,     I_NOP,  1'b1, 1'b0, 1, 1'b1, 2'b00, 2'b10, 2'b11));
      tbl.push_back(mk(2'b00, 32'h0,     I_NOP,  32'h0,     I_NOP,  1'b1, 1'b0, 2, 1'b1, 2'b11, 2'b10, 2'b11));
      // jr in last lane is held for the next group
      tbl.push_back(mk(2'b11, 32'h300,   I_ADDU, 32'h304,   I_JR,   1'b0, 1'b0, 0, 1'b1, 2'b00, 2'b00, 2'b01));
      tbl.push_back(mk(2'b01, 32'h308,   I_NOP,  32'h0,     I_NOP,  1'b0, 1'b0, 2, 1'b1, 2'b01, 2'b00, 2'b11));
      tbl.push_back(mk(2'b00, 32'h0,     I_NOP,  32'h0,     I_NOP,  1'b1, 1'b0, 3, 1'b1, 2'b01, 2'b00, 2'b11));
      tbl.push_back(mk(2'b00, 32'h0,     I_NOP,  32'h0,     I_NOP,  1'b1, 1'b0, 2, 1'b1, 2'b11, 2'b10, 2'b11));
      // fill to 7, dropped write, drain 2, refill across the pointer wrap
      tbl.push_back(mk(2'b11, 32'h500,   I_ADDU, 32'h504,   I_LW,   1'b0, 1'b0, 0, 1'b1, 2'b00, 2'b00, 2'b01));
      tbl.push_back(mk(2'b11, 32'h508,   I_ADDU, 32'h50C,   I_LW,   1'b0, 1'b0, 2, 1'b1, 2'b11, 2'b00, 2'b11));
      tbl.push_back(mk(2'b11, 32'h510,   I_ADDU, 32'h514,   I_LW,   1'b0, 1'b0, 4, 1'b1, 2'b11, 2'b00, 2'b11));
      tbl.push_back(mk(2'b01, 32'h518,   I_ADDU, 32'h0,     I_NOP,  1'b0, 1'b0, 6, 1'b1, 2'b11, 2'b00, 2'b11));
      tbl.push_back(mk(2'b11, 32'h51C,   I_ADDU, 32'h520,   I_LW,   1'b0, 1'b0, 7, 1'b0, 2'b11, 2'b00, 2'b11));
      tbl.push_back(mk(2'b00, 32'h0,     I_NOP,  32'h0,     I_NOP,  1'b1, 1'b0, 7, 1'b0, 2'b11, 2'b00, 2'b11));
      tbl.push_back(mk(2'b00, 32'h0,     I_NOP,  32'h0,     I_NOP,  1'b0, 1'b0, 5, 1'b1, 2'b11, 2'b00, 2'b11));
      tbl.push_back(mk(2'b11, 32'h600,   I_ADDU, 32'h604,   I_LW,   1'b1, 1'b0, 5, 1'b1, 2'b11, 2'b00, 2'b11));
      tbl.push_back(mk(2'b11, 32'h608,   I_ADDU, 32'h60C,   I_LW,   1'b1, 1'b0, 5, 1'b1, 2'b11, 2'b00, 2'b11));
      tbl.push_back(mk(2'b00, 32'h0,     I_NOP,  32'h0,     I_NOP,  1'b1, 1'b0, 5, 1'b1, 2'b11, 2'b00, 2'b11));
      tbl.push_back(mk(2'b00, 32'h0,     I_NOP,  32'h0,     I_NOP,  1'b1, 1'b0, 3, 1'b1, 2'b11, 2'b00, 2'b11));
      tbl.push_back(mk(2'b00, 32'h0,     I_NOP,  32'h0,     I_NOP,  1'b1, 1'b0, 1, 1'b1, 2'b01, 2'b00, 2'b11));
      tbl.push_back(mk(2'b00, 32'h0,     I_NOP,  32'h0,     I_NOP,  1'b0, 1'b0, 0, 1'b1, 2'b00, 2'b00, 2'b01));
      // flush beats a same-cycle enqueue and dequeue
      tbl.push_back(mk(2'b11, 32'h700,   I_ADDU, 32'h704,   I_LW,   1'b0, 1'b0, 0, 1'b1, 2'b00, 2'b00, 2'b01));
      tbl.push_back(mk(2'b11, 32'h708,   I_ADDU, 32'h70C,   I_LW,   1'b1, 1'b1, 2, 1'b1, 2'b11, 2'b00, 2'b11));
      tbl.push_back(mk(2'b00, 32'h0,     I_NOP,  32'h0,     I_NOP,  1'b0, 1'b0, 0, 1'b1, 2'b00, 2'b00, 2'b01));

      repeat (2) @(negedge clk);
      reset = 1'b0;

      for (int r = 0; r < tbl.size(); r++) begin
         v = tbl[r];
         @(negedge clk);
         in_valid    = v.iv;
         in_entry[0] = fe(v.pc0, v.ins0);
         in_entry[1] = fe(v.pc1, v.ins1);
         out_ready   = v.ordy;
         flush       = v.fl;
         #1;
         check($sformatf("row%0d count", r),     64'(count),              64'(v.cnt));
         check($sformatf("row%0d in_ready", r),  64'(in_ready),           64'(v.ir));
         check($sformatf("row%0d out_valid", r), 64'(out_valid),          64'(v.ov));
         check($sformatf("row%0d in_ds", r),     64'(out_ds & v.dsm),     64'(v.ds & v.dsm));
         if (v.fl) begin
            sb.delete();
         end else begin
            if (v.ordy)
               for (int l = 0; l < IW; l++)
                  if (v.ov[l])
                     sb_pop($sformatf("row%0d lane%0d pc", r, l), out_entry[l].pc);
            if (v.ir) begin
               if (v.iv[0]) sb.push_back(v.pc0);
               if (v.iv[1]) sb.push_back(v.pc1);
            end
         end
      end

      @(negedge clk);
      in_valid = '0; out_ready = 1'b0; flush = 1'b0;
      check("sb_drained", 64'(sb.size()), 64'd0);

      // single-issue: j and its slot leave in consecutive cycles
      @(negedge clk);
      in_valid_s    = 2'b11;
      in_entry_s[0] = fe(32'h400, I_J);
      in_entry_s[1] = fe(32'h404, I_NOP);
      in_valid      = 2'b11;                        // give the wide queue content too
      in_entry[0]   = fe(32'h800, I_ADDU);
      in_entry[1]   = fe(32'h804, I_LW);
      #1;
      check("s1 count", 64'(count_s), 64'd0);
      check("s1 in_ready", 64'(in_ready_s), 64'd1);

      @(negedge clk);
      in_valid_s = '0; in_valid = '0; out_ready_s = 1'b1;
      #1;
      check("s2 count", 64'(count_s), 64'd2);
      check("s2 out_valid", 64'(out_valid_s), 64'd1);
      check("s2 pc", 64'(out_entry_s[0].pc), 64'h400);
      check("s2 in_ds", 64'(out_ds_s), 64'd0);

      @(negedge clk);
      out_ready_s = 1'b0;
      #1;
      check("s3 count", 64'(count_s), 64'd1);
      check("s3 out_valid", 64'(out_valid_s), 64'd1);
      check("s3 pc", 64'(out_entry_s[0].pc), 64'h404);
      check("s3 in_ds", 64'(out_ds_s), 64'd1);
      check("s3 wide count", 64'(count), 64'd2);

      // asynchronous reset mid-cycle: state clears without a clock edge
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("rst count_s", 64'(count_s), 64'd0);
      check("rst out_valid_s", 64'(out_valid_s), 64'd0);
      check("rst in_ds_s", 64'(out_ds_s), 64'd0);
      check("rst in_ready_s", 64'(in_ready_s), 64'd1);
      check("rst count", 64'(count), 64'd0);
      check("rst out_valid", 64'(out_valid), 64'd0);
      check("rst in_ready", 64'(in_ready), 64'd1);
      #1;
      reset = 1'b0;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised instruction buffer between fetch and decode.
- Accepts up to FETCH_WIDTH fetched instructions per cycle and presents up to ISSUE_WIDTH instructions per cycle to the decoder lanes.
- Pre-decodes control-transfer instructions (CTIs) so that a branch/jump and its delay slot leave the queue in the same issue group.
- Generates a per-lane in_delay_slot flag, replacing the single-lane delay-slot register inside decode.

Parameters:
- FETCH_WIDTH, 2, fetch lanes written per cycle (1..4).
- ISSUE_WIDTH, 2, decode lanes read per cycle (1..4).
- DEPTH, 8, queue entries; power of two, and DEPTH >= FETCH_WIDTH + ISSUE_WIDTH.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- flush  in  1  discard all contents (exception, eret, mispredict)
- in_valid  in  FETCH_WIDTH  per-lane valid; must be contiguous from lane 0
- in_entry  in  FETCH_WIDTH x fetch_entry_t  pc, raw_instr, exception_instr, i_tlb_refill, i_tlb_invalid, i_tlb_modified
- in_ready  out  1  high when free entries >= FETCH_WIDTH
- out_valid  out  ISSUE_WIDTH  per-lane valid, contiguous from lane 0
- out_entry  out  ISSUE_WIDTH x fetch_entry_t  head-ordered entries
- out_in_delay_slot  out  ISSUE_WIDTH  lane holds a delay-slot instruction
- out_ready  in  1  decode consumes every valid lane this cycle
- count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset values: count 0, pointers 0, ds_pending 0, out_valid 0, in_ready 1.
- Storage: circular buffer with head/tail pointers; wrap modulo DEPTH.
- Enqueue fires when in_ready & |in_valid.
  - Writes popcount(in_valid) entries at the tail, in lane order.
  - All-or-nothing: there are no partial writes.
- Latency: an entry written in cycle N is visible on out_* in cycle N+1. There is no bypass.
- Candidate lanes: lane i is a candidate when i < count. It shows entry head+i.
- Pre-decode is_cti(raw_instr) returns 1 for:
  - opcode 000010, 000011, 000100-000111, 000001
  - opcode 000000 with funct 001000 or 001001
- Pairing rule (ISSUE_WIDTH >= 2):
  - The first candidate lane k that is a CTI with no candidate k+1 is invalid, and so are all lanes above it.
  - A CTI in the last lane (ISSUE_WIDTH-1) is likewise held for the next group.
  - Result: a branch always issues together with its delay slot.
- Pairing rule (ISSUE_WIDTH == 1): no holding.
  - ds_pending is set when a CTI is dequeued and cleared when any other instruction is dequeued.
- out_in_delay_slot:
  - lane 0 = ds_pending.
  - lane i>0 = is_cti(lane i-1).
- Dequeue: when out_ready & |out_valid, head advances by popcount(out_valid).
  - out_ready with no valid lanes is a no-op.
  - ds_pending updates from the last dequeued lane.
- Simultaneous enqueue and dequeue: count_next = count + n_in - n_out. The result never exceeds DEPTH.
  - in_ready is computed from the current count only, not from the same-cycle dequeue.
- Flush is synchronous and takes priority.
  - Sets count, head, tail and ds_pending to 0.
  - Same-cycle enqueue and dequeue are ignored.
  - out_valid is 0 in the next cycle.
- Full (count > DEPTH-FETCH_WIDTH): in_ready is 0. in_valid is ignored.
- Empty: out_valid is 0. Output data is don't-care; it is driven from head without X-gating.
- Non-contiguous in_valid is illegal. An assertion flags it in simulation.
- Reset asserted mid-operation: all state clears immediately (asynchronous), and outputs return to their reset values in the same cycle.

Decomposition:
- Shared package decode_pkg holds:
  - the fetch_entry_t typedef
  - opcode/funct constants for the CTI set
  - the pure function is_cti.
- Sub-module decode_queue_select, combinational: takes the candidate entries and count, and produces out_valid and out_in_delay_slot (the pairing logic).
- Storage and pointers stay in the top module.

Test Plan:
- Defaults. Enqueue addu@0x100, lw@0x104; next cycle -> out_valid=2'b11, pcs 0x100/0x104, out_in_delay_slot=00. out_ready=1 -> count=0.
- Enqueue beq@0x200 alone, then hold in_valid=0 -> out_valid=00 for 3 cycles. Enqueue nop@0x204 -> next cycle out_valid=11, out_in_delay_slot=2'b10.
- Queue holds addu@0x300, jr@0x304, nop@0x308 -> group 1: lane 0 only (0x300). Group 2: 0x304/0x308, out_in_delay_slot=10.
- Fill to 7 of 8 -> in_ready=0, and a 2-lane write is dropped (count stays 7). Dequeue 2 -> count=5, in_ready=1. Fill again past the pointer wrap -> entries emerge in order.
- Flush in the same cycle as a valid enqueue and out_ready -> count=0 next cycle, out_valid=0, no entry written.
- ISSUE_WIDTH=1 build: j@0x400 then nop@0x404 -> 0x400 issued with in_delay_slot=0. 0x404 issued next with in_delay_slot=1. Assert reset mid-stream -> count=0 immediately.
